aes_mode_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 8 +
 rtl/aes_blk_fifo.sv | 40 ++++
 rtl/aes_mode_ctrl.sv | 107 ++++++++++
 tb/tb_aes_mode_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared mode encodings, controller state type and default block width.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;
    localparam logic [1:0] MODE_ECB = 2'd0;
    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_e;
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: synchronous block FIFO; pointers carry an extra wrap bit to tell full from empty.
module aes_blk_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic do_push, do_pop;
    always_comb begin
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty_o = wptr_q == rptr_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + (AW+1)'(1) : rptr_q;
        rdata_o = mem_q[rptr_q[AW-1:0]];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: buffers plaintext, drives the iterative AES core one block at a time
// and applies ECB/CBC/CTR chaining around it with a valid/ready result port.
module aes_mode_ctrl
    import aes_pkg::*;
#(
    parameter int BLOCK_W    = AES_BLOCK_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [BLOCK_W-1:0] cfg_iv_i,
    input  logic               cfg_load_i,
    input  logic [BLOCK_W-1:0] s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [BLOCK_W-1:0] m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               core_start_o,
    output logic [BLOCK_W-1:0] core_data_o,
    input  logic               core_busy_i,
    input  logic [BLOCK_W-1:0] core_data_i,
    input  logic               core_valid_i,
    output logic               busy_o,
    output logic [31:0]        blk_cnt_o
);
    state_e state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [BLOCK_W-1:0] pt_q, pt_d, chain_q, chain_d, ctr_q, ctr_d;
    logic [BLOCK_W-1:0] core_data_q, core_data_d, m_data_q, m_data_d, issue_data;
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic [BLOCK_W-1:0] fifo_rdata;
    logic fifo_full, fifo_empty, pop, res_ok, cfg_ok;

    aes_blk_fifo #(.W(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s_valid_i && s_ready_o),
        .pop_i   (pop),
        .wdata_i (s_data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = !fifo_empty ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = !core_busy_i ? ST_WAIT : ST_ISSUE;
            ST_WAIT:  state_d = core_valid_i ? ST_HOLD : ST_WAIT;
            ST_HOLD:  state_d = m_ready_i ? (!fifo_empty ? ST_ISSUE : ST_IDLE) : ST_HOLD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Core input is formed while popping so it is ready in the first ISSUE cycle.
    always_comb begin
        busy_o       = (state_q != ST_IDLE) || !fifo_empty;
        s_ready_o    = !fifo_full && !rst_i;
        m_valid_o    = state_q == ST_HOLD;
        m_data_o     = m_data_q;
        core_data_o  = core_data_q;
        core_start_o = (state_q == ST_ISSUE) && !core_busy_i;
        blk_cnt_o    = blk_cnt_q;
        pop          = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_HOLD && m_ready_i));
        res_ok       = (state_q == ST_WAIT) && core_valid_i;
        cfg_ok       = cfg_load_i && !busy_o;
        issue_data   = mode_q == MODE_CBC ? fifo_rdata ^ chain_q :
                       mode_q == MODE_CTR ? ctr_q : fifo_rdata;
        pt_d         = pop ? fifo_rdata : pt_q;
        core_data_d  = pop ? issue_data : core_data_q;
        m_data_d     = !res_ok ? m_data_q :
                       mode_q == MODE_CTR ? pt_q ^ core_data_i : core_data_i;
        mode_d       = cfg_ok ? cfg_mode_i : mode_q;
        chain_d      = cfg_ok ? cfg_iv_i :
                       (res_ok && mode_q == MODE_CBC) ? core_data_i : chain_q;
        ctr_d        = cfg_ok ? cfg_iv_i :
                       (res_ok && mode_q == MODE_CTR) ?
                       {ctr_q[BLOCK_W-1:CTR_W], ctr_q[CTR_W-1:0] + CTR_W'(1)} : ctr_q;
        blk_cnt_d    = (state_q == ST_HOLD && m_ready_i) ? blk_cnt_q + 32'd1 : blk_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ECB;
            pt_q        <= '0;
            chain_q     <= '0;
            ctr_q       <= '0;
            core_data_q <= '0;
            m_data_q    <= '0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pt_q        <= pt_d;
            chain_q     <= chain_d;
            ctr_q       <= ctr_d;
            core_data_q <= core_data_d;
            m_data_q    <= m_data_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: directed checks of the mode controller against an XOR-based core model.
module tb_aes_mode_ctrl;
    localparam logic [127:0] K = {16{8'hA5}};
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [1:0]   cfg_mode_i = '0;
    logic [127:0] cfg_iv_i = '0;
    logic         cfg_load_i = 1'b0;
    logic [127:0] s_data_i = '0;
    logic         s_valid_i = 1'b0;
    logic         s_ready_o;
    logic [127:0] m_data_o;
    logic         m_valid_o;
    logic         m_ready_i = 1'b0;
    logic         core_start_o;
    logic [127:0] core_data_o;
    logic         core_busy_i = 1'b0;
    logic [127:0] core_data_i = '0;
    logic         core_valid_i = 1'b0;
    logic         busy_o;
    logic [31:0]  blk_cnt_o;
    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] core_in_q [$];
    logic [127:0] core_lat = '0;
    int core_cnt = 0;

    aes_mode_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_mode_i(cfg_mode_i), .cfg_iv_i(cfg_iv_i),
        .cfg_load_i(cfg_load_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .core_start_o(core_start_o), .core_data_o(core_data_o),
        .core_busy_i(core_busy_i), .core_data_i(core_data_i), .core_valid_i(core_valid_i),
        .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Core model: result = input ^ K, valid 10 cycles after start, busy in between.
    always @(posedge clk_i) begin
        core_valid_i <= 1'b0;
        if (core_start_o && core_busy_i) begin
            $display("FAIL start_while_busy got start=1 busy=1 exp no start");
            n_bad++;
        end
        if (core_start_o && !core_busy_i) begin
            core_in_q.push_back(core_data_o);
            core_lat    <= core_data_o;
            core_cnt    <= 10;
            core_busy_i <= 1'b1;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_valid_i <= 1'b1;
                core_data_i  <= core_lat ^ K;
                core_busy_i  <= 1'b0;
            end
        end
    end

    task automatic push(input logic [127:0] d);
        s_data_i = d; s_valid_i = 1'b1;
        @(negedge clk_i);
        s_valid_i = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [127:0] iv);
        cfg_mode_i = m; cfg_iv_i = iv; cfg_load_i = 1'b1;
        @(negedge clk_i);
        cfg_load_i = 1'b0;
    endtask

    task automatic get_out(output logic [127:0] d);
        int n = 0;
        m_ready_i = 1'b1;
        while (!m_valid_o && n < 200) begin @(negedge clk_i); n++; end
        n_cmp++;
        if (!m_valid_o) begin $display("FAIL out_timeout got m_valid=0 exp 1"); n_bad++; end
        d = m_data_o;
        @(negedge clk_i);
        m_ready_i = 1'b0;
    endtask

    task automatic chk_core(input string nm, input logic [127:0] exp);
        logic [127:0] got = 'x;
        if (core_in_q.size() > 0) got = core_in_q.pop_front();
        n_cmp++;
        if (got !== exp) begin $display("FAIL %s got %h exp %h", nm, got, exp); n_bad++; end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_cmp++; if (s_ready_o !== 1'b0) begin $display("FAIL rst_s_ready got %b exp 0", s_ready_o); n_bad++; end
        n_cmp++; if (m_valid_o !== 1'b0) begin $display("FAIL rst_m_valid got %b exp 0", m_valid_o); n_bad++; end
        n_cmp++; if (busy_o !== 1'b0) begin $display("FAIL rst_busy got %b exp 0", busy_o); n_bad++; end
        n_cmp++; if (blk_cnt_o !== 32'd0) begin $display("FAIL rst_blk_cnt got %0d exp 0", blk_cnt_o); n_bad++; end
        n_cmp++; if (core_start_o !== 1'b0) begin $display("FAIL rst_core_start got %b exp 0", core_start_o); n_bad++; end
        n_cmp++; if (core_data_o !== '0) begin $display("FAIL rst_core_data got %h exp 0", core_data_o); n_bad++; end
        n_cmp++; if (m_data_o !== '0) begin $display("FAIL rst_m_data got %h exp 0", m_data_o); n_bad++; end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (s_ready_o !== 1'b1) begin $display("FAIL post_rst_s_ready got %b exp 1", s_ready_o); n_bad++; end
    endtask

    task automatic test_ecb;
        logic [127:0] d;
        core_in_q.delete();
        cfg(2'd0, '0);
        push('0);
        n_cmp++; if (busy_o !== 1'b1) begin $display("FAIL ecb_busy got %b exp 1", busy_o); n_bad++; end
        n_cmp++; if (core_start_o !== 1'b0) begin $display("FAIL ecb_start_early got %b exp 0", core_start_o); n_bad++; end
        @(negedge clk_i);
        n_cmp++; if (core_start_o !== 1'b1) begin $display("FAIL ecb_start_t2 got %b exp 1", core_start_o); n_bad++; end
        get_out(d);
        n_cmp++; if (d !== K) begin $display("FAIL ecb_data got %h exp %h", d, K); n_bad++; end
        chk_core("ecb_core_in", '0);
        n_cmp++; if (blk_cnt_o !== 32'd1) begin $display("FAIL ecb_blk_cnt got %0d exp 1", blk_cnt_o); n_bad++; end
    endtask

    task automatic test_cbc;
        logic [127:0] d;
        core_in_q.delete();
        cfg(2'd1, 128'h1);
        push('0);
        push('0);
        get_out(d);
        n_cmp++; if (d !== (K ^ 128'h1)) begin $display("FAIL cbc_out1 got %h exp %h", d, K ^ 128'h1); n_bad++; end
        get_out(d);
        n_cmp++; if (d !== 128'h1) begin $display("FAIL cbc_out2 got %h exp %h", d, 128'h1); n_bad++; end
        chk_core("cbc_core_in1", 128'h1);
        chk_core("cbc_core_in2", K ^ 128'h1);
        n_cmp++; if (blk_cnt_o !== 32'd3) begin $display("FAIL cbc_blk_cnt got %0d exp 3", blk_cnt_o); n_bad++; end
    endtask

    task automatic test_ctr_wrap;
        logic [127:0] d;
        core_in_q.delete();
        cfg(2'd2, 128'hFFFF_FFFF);
        push('0);
        push('0);
        get_out(d);
        n_cmp++; if (d !== (K ^ 128'hFFFF_FFFF)) begin $display("FAIL ctr_out1 got %h exp %h", d, K ^ 128'hFFFF_FFFF); n_bad++; end
        get_out(d);
        n_cmp++; if (d !== K) begin $display("FAIL ctr_out2 got %h exp %h", d, K); n_bad++; end
        chk_core("ctr_core_in1", 128'hFFFF_FFFF);
        chk_core("ctr_core_in2", 128'h0);
        n_cmp++; if (blk_cnt_o !== 32'd5) begin $display("FAIL ctr_blk_cnt got %0d exp 5", blk_cnt_o); n_bad++; end
    endtask

    task automatic test_backpressure;
        logic [127:0] d, held;
        int n = 0;
        cfg(2'd0, '0);
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_data_i = 128'h100 + 128'(i); s_valid_i = 1'b1;
            n_cmp++;
            if (s_ready_o !== (i < 5)) begin $display("FAIL bp_ready%0d got %b exp %b", i, s_ready_o, i < 5); n_bad++; end
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        while (!m_valid_o && n < 200) begin @(negedge clk_i); n++; end
        held = m_data_o;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (m_valid_o !== 1'b1) begin $display("FAIL bp_valid_hold got %b exp 1", m_valid_o); n_bad++; end
        n_cmp++; if (m_data_o !== held || held !== (K ^ 128'h100)) begin $display("FAIL bp_data_hold got %h exp %h", m_data_o, K ^ 128'h100); n_bad++; end
        for (int i = 0; i < 5; i++) begin
            get_out(d);
            n_cmp++;
            if (d !== (K ^ (128'h100 + 128'(i)))) begin $display("FAIL bp_order%0d got %h exp %h", i, d, K ^ (128'h100 + 128'(i))); n_bad++; end
        end
        n_cmp++; if (busy_o !== 1'b0) begin $display("FAIL bp_idle_busy got %b exp 0", busy_o); n_bad++; end
        n_cmp++; if (blk_cnt_o !== 32'd10) begin $display("FAIL bp_blk_cnt got %0d exp 10", blk_cnt_o); n_bad++; end
    endtask

    task automatic test_cfg_busy;
        logic [127:0] d;
        core_in_q.delete();
        cfg(2'd1, 128'h1);
        push('0);
        cfg(2'd0, 128'hFFFF);
        get_out(d);
        n_cmp++; if (d !== (K ^ 128'h1)) begin $display("FAIL cfg_busy_out got %h exp %h", d, K ^ 128'h1); n_bad++; end
        chk_core("cfg_busy_core_in", 128'h1);
    endtask

    task automatic test_reset_mid_wait;
        int n = 0;
        bit seen = 0;
        cfg(2'd0, '0);
        push(128'h55);
        while (!core_start_o && n < 50) begin @(negedge clk_i); n++; end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0) begin $display("FAIL rmw_busy got %b exp 0", busy_o); n_bad++; end
        n_cmp++; if (blk_cnt_o !== 32'd0) begin $display("FAIL rmw_blk_cnt got %0d exp 0", blk_cnt_o); n_bad++; end
        n_cmp++; if (m_data_o !== '0) begin $display("FAIL rmw_m_data got %h exp 0", m_data_o); n_bad++; end
        n_cmp++; if (core_data_o !== '0) begin $display("FAIL rmw_core_data got %h exp 0", core_data_o); n_bad++; end
        n_cmp++; if (s_ready_o !== 1'b0) begin $display("FAIL rmw_s_ready got %b exp 0", s_ready_o); n_bad++; end
        rst_i = 1'b0;
        m_ready_i = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (m_valid_o) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin $display("FAIL rmw_late_valid got m_valid=1 exp 0"); n_bad++; end
        n_cmp++; if (busy_o !== 1'b0) begin $display("FAIL rmw_late_busy got %b exp 0", busy_o); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_ecb();
        test_cbc();
        test_ctr_wrap();
        test_backpressure();
        test_cfg_busy();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
